// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: scan coordinates, sync/blank qualifiers and their pipelined copies.
// master = timing generator, slave = drawing stages / VGA connector.
`timescale 1ns/1ps
interface vga_timing_gen_if;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        hs;
  logic        vs;
  logic        blank;
  logic        frame_start;
  logic        line_start;
  logic [15:0] frame_count;
  logic        hs_pipe;
  logic        vs_pipe;
  logic        blank_pipe;

  modport master (
    output DrawX, DrawY, hs, vs, blank, frame_start, line_start,
    output frame_count, hs_pipe, vs_pipe, blank_pipe
  );

  modport slave (
    input DrawX, DrawY, hs, vs, blank, frame_start, line_start,
    input frame_count, hs_pipe, vs_pipe, blank_pipe
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: registered scan position, sync and blank, one cycle after the counters.
// Free-running, no backpressure; *_pipe outputs trail the aligned ones by PIPE_DELAY cycles.
`timescale 1ns/1ps
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DELAY = 2
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  vga_timing_gen_if.master  vga
);
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 10-bit counter range");
  end
  if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_bad_pipe
    $error("vga_timing_gen: PIPE_DELAY must be 0..7");
  end

  logic [9:0]  hc_q, hc_d, vc_q, vc_d;
  logic [9:0]  draw_x_q, draw_x_d, draw_y_q, draw_y_d;
  logic        hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
  logic        frame_start_q, frame_start_d, line_start_q, line_start_d;
  logic [15:0] frame_count_q, frame_count_d;

  always_comb begin
    hc_d = hc_q + 10'd1;
    vc_d = vc_q;
    if (hc_q == 10'(H_TOTAL - 1)) begin
      hc_d = 10'd0;
      vc_d = (vc_q == 10'(V_TOTAL - 1)) ? 10'd0 : vc_q + 10'd1;
    end

    draw_x_d      = hc_q;
    draw_y_d      = vc_q;
    hs_d          = !((int'(hc_q) >= HS_START) && (int'(hc_q) < HS_END));
    vs_d          = !((int'(vc_q) >= VS_START) && (int'(vc_q) < VS_END));
    blank_d       = (int'(hc_q) < H_ACTIVE) && (int'(vc_q) < V_ACTIVE);
    frame_start_d = (hc_q == 10'd0) && (vc_q == 10'd0);
    line_start_d  = (hc_q == 10'd0);

    // The registered position is still (0,0) only for the very first frame after reset.
    frame_count_d = frame_count_q;
    if (frame_start_d && ((draw_x_q != 10'd0) || (draw_y_q != 10'd0)))
      frame_count_d = frame_count_q + 16'd1;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc_q          <= '0;
      vc_q          <= '0;
      draw_x_q      <= '0;
      draw_y_q      <= '0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_q       <= 1'b0;
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      draw_x_q      <= draw_x_d;
      draw_y_q      <= draw_y_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_q       <= blank_d;
      frame_start_q <= frame_start_d;
      line_start_q  <= line_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign vga.DrawX       = draw_x_q;
  assign vga.DrawY       = draw_y_q;
  assign vga.hs          = hs_q;
  assign vga.vs          = vs_q;
  assign vga.blank       = blank_q;
  assign vga.frame_start = frame_start_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_count = frame_count_q;

  // Each stage holds {hs, vs, blank}.
  if (PIPE_DELAY == 0) begin : g_no_pipe
    assign vga.hs_pipe    = hs_q;
    assign vga.vs_pipe    = vs_q;
    assign vga.blank_pipe = blank_q;
  end else begin : g_pipe
    logic [2:0] pipe_q [PIPE_DELAY];
    logic [2:0] pipe_d [PIPE_DELAY];

    always_comb begin
      pipe_d[0] = {hs_q, vs_q, blank_q};
      for (int i = 1; i < PIPE_DELAY; i++)
        pipe_d[i] = pipe_q[i-1];
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < PIPE_DELAY; i++)
          pipe_q[i] <= 3'b110;
      end else begin
        for (int i = 0; i < PIPE_DELAY; i++)
          pipe_q[i] <= pipe_d[i];
      end
    end

    assign vga.hs_pipe    = pipe_q[PIPE_DELAY-1][2];
    assign vga.vs_pipe    = pipe_q[PIPE_DELAY-1][1];
    assign vga.blank_pipe = pipe_q[PIPE_DELAY-1][0];
  end
endmodule
